// File: rtl/intersection_pkg.sv
// rtl/intersection_pkg.sv - Shared state codes, lamp constants and lamp decode for the intersection controller
//
// Contents:
//   state_t       - FSM state codes 0..6 (code 7 is illegal)
//   LIGHT_*       - {red, yellow, green} lamp encodings
//   lamps_t       - registered lamp bundle driven by the top
//   decode_lamps  - lamp pattern for a given state
package intersection_pkg;

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_1   = 3'd2,
        PED_WALK    = 3'd3,
        SIDE_GREEN  = 3'd4,
        SIDE_YELLOW = 3'd5,
        ALL_RED_2   = 3'd6
    } state_t;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    typedef struct packed {
        logic [2:0] main_light;
        logic [2:0] side_light;
        logic       ped_walk;
    } lamps_t;

    // Anything unrecognised shows the main-green pattern, matching where the
    // FSM recovers to.
    function automatic lamps_t decode_lamps(input state_t s);
        lamps_t l;
        l = '{main_light: LIGHT_GREEN, side_light: LIGHT_RED, ped_walk: 1'b0};
        case (s)
            MAIN_GREEN:  l = '{main_light: LIGHT_GREEN,  side_light: LIGHT_RED,    ped_walk: 1'b0};
            MAIN_YELLOW: l = '{main_light: LIGHT_YELLOW, side_light: LIGHT_RED,    ped_walk: 1'b0};
            ALL_RED_1:   l = '{main_light: LIGHT_RED,    side_light: LIGHT_RED,    ped_walk: 1'b0};
            PED_WALK:    l = '{main_light: LIGHT_RED,    side_light: LIGHT_RED,    ped_walk: 1'b1};
            SIDE_GREEN:  l = '{main_light: LIGHT_RED,    side_light: LIGHT_GREEN,  ped_walk: 1'b0};
            SIDE_YELLOW: l = '{main_light: LIGHT_RED,    side_light: LIGHT_YELLOW, ped_walk: 1'b0};
            ALL_RED_2:   l = '{main_light: LIGHT_RED,    side_light: LIGHT_RED,    ped_walk: 1'b0};
            default:     l = '{main_light: LIGHT_GREEN,  side_light: LIGHT_RED,    ped_walk: 1'b0};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/intersection_controller_tick_prescaler.sv
// rtl/intersection_controller_tick_prescaler.sv - Divides the system clock down to a one-cycle 1-second tick
//
// Ports:
//   clock_100mhz - system clock
//   rst_n_i      - asynchronous active-low reset
//   clear_i      - restart the count from 0 (phase change)
//   tick_o       - high for one cycle when the count reaches TICK_DIV-1
module tick_prescaler #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clock_100mhz,
    input  logic rst_n_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock_100mhz or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count <= '0;
        end else if (clear_i || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick_o = (count == LAST);

endmodule

// File: rtl/intersection_controller.sv
// rtl/intersection_controller.sv - Traffic-light sequencer for main road, side road and pedestrian crossing
//
// Ports:
//   clock_100mhz     - system clock
//   rst_n_i          - asynchronous active-low reset
//   pressed_button_i - pedestrian request (may be held high)
//   side_car_i       - side-road vehicle present (level)
//   main_light_o     - main-road {red, yellow, green}
//   side_light_o     - side-road {red, yellow, green}
//   ped_walk_o       - pedestrian walk lamp
//   ped_request_o    - pedestrian request pending
//   side_request_o   - side request pending
//   state_o          - current state code
//   seconds_left_o   - seconds remaining in the current phase
module intersection_controller
    import intersection_pkg::*;
#(
    parameter int TICK_DIV     = 100_000_000,
    parameter int MIN_GREEN    = 10,
    parameter int T_YELLOW     = 3,
    parameter int T_ALL_RED    = 2,
    parameter int T_GREEN_SIDE = 15,
    parameter int T_PED_WALK   = 10,
    parameter int CNT_W        = 8
) (
    input  logic             clock_100mhz,
    input  logic             rst_n_i,
    input  logic             pressed_button_i,
    input  logic             side_car_i,
    output logic [2:0]       main_light_o,
    output logic [2:0]       side_light_o,
    output logic             ped_walk_o,
    output logic             ped_request_o,
    output logic             side_request_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] seconds_left_o
);

    state_t           state, state_next;
    logic [CNT_W-1:0] secs, secs_next;
    logic             tick;
    logic             changing;
    logic             button_q;
    logic             ped_req, side_req;
    lamps_t           lamps_q;

    function automatic logic [CNT_W-1:0] phase_len(input state_t s);
        case (s)
            MAIN_YELLOW, SIDE_YELLOW: return CNT_W'(T_YELLOW);
            ALL_RED_1, ALL_RED_2:     return CNT_W'(T_ALL_RED);
            PED_WALK:                 return CNT_W'(T_PED_WALK);
            SIDE_GREEN:               return CNT_W'(T_GREEN_SIDE);
            default:                  return CNT_W'(MIN_GREEN);
        endcase
    endfunction

    assign changing = (state_next != state);

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clock_100mhz (clock_100mhz),
        .rst_n_i      (rst_n_i),
        .clear_i      (changing),
        .tick_o       (tick)
    );

    always_ff @(posedge clock_100mhz or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= MAIN_GREEN;
            secs  <= CNT_W'(MIN_GREEN);
        end else begin
            state <= state_next;
            secs  <= secs_next;
        end
    end

    // Timed phases end on the tick that would take the counter from 1 to 0,
    // so each lasts exactly T ticks. Main green instead parks at 0 and waits
    // for a request.
    always_comb begin
        state_next = state;
        secs_next  = secs;
        case (state)
            MAIN_GREEN: begin
                if (secs == '0) begin
                    if (ped_req || side_req) state_next = MAIN_YELLOW;
                end else if (tick) begin
                    secs_next = secs - 1'b1;
                end
            end
            MAIN_YELLOW, ALL_RED_1, PED_WALK, SIDE_GREEN, SIDE_YELLOW, ALL_RED_2: begin
                if (tick) begin
                    if (secs == CNT_W'(1)) begin
                        case (state)
                            MAIN_YELLOW: state_next = ALL_RED_1;
                            ALL_RED_1:   state_next = ped_req  ? PED_WALK :
                                                      side_req ? SIDE_GREEN : MAIN_GREEN;
                            PED_WALK:    state_next = ALL_RED_2;
                            SIDE_GREEN:  state_next = SIDE_YELLOW;
                            SIDE_YELLOW: state_next = ALL_RED_2;
                            default:     state_next = MAIN_GREEN;
                        endcase
                    end else begin
                        secs_next = secs - 1'b1;
                    end
                end
            end
            default: state_next = MAIN_GREEN;
        endcase
        if (state_next != state) secs_next = phase_len(state_next);
    end

    // Request latches: clear on entry to the serving phase beats any set in
    // the same cycle. A held button only counts its rising edge.
    always_ff @(posedge clock_100mhz or negedge rst_n_i) begin
        if (!rst_n_i) begin
            button_q <= 1'b0;
            ped_req  <= 1'b0;
            side_req <= 1'b0;
        end else begin
            button_q <= pressed_button_i;
            if (state_next == PED_WALK && state != PED_WALK) begin
                ped_req <= 1'b0;
            end else if (pressed_button_i && !button_q && state != PED_WALK) begin
                ped_req <= 1'b1;
            end
            if (state_next == SIDE_GREEN && state != SIDE_GREEN) begin
                side_req <= 1'b0;
            end else if (side_car_i && state != SIDE_GREEN && state != SIDE_YELLOW) begin
                side_req <= 1'b1;
            end
        end
    end

    // Lamps are registered from the next state so they change on the same
    // edge as the state register.
    always_ff @(posedge clock_100mhz or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lamps_q <= '{main_light: LIGHT_GREEN, side_light: LIGHT_RED, ped_walk: 1'b0};
        end else begin
            lamps_q <= decode_lamps(state_next);
        end
    end

    assign main_light_o   = lamps_q.main_light;
    assign side_light_o   = lamps_q.side_light;
    assign ped_walk_o     = lamps_q.ped_walk;
    assign ped_request_o  = ped_req;
    assign side_request_o = side_req;
    assign state_o        = state;
    assign seconds_left_o = secs;

endmodule

// File: doc/intersection_controller.md
Name: intersection_controller

Overview:
- Central traffic-light sequencer for the automatic intersection.
- Consumes the debounced pedestrian pulse `pressed_button_i` from the button driver and a side-road vehicle sensor.
- Drives main-road, side-road and pedestrian lights through timed phases, using an internal 1-second tick derived from the system clock.
- Main road rests on green; side-road and pedestrian service is granted on request after a minimum main green.

Parameters:
- TICK_DIV, 100_000_000: system clocks per 1-second tick.
- MIN_GREEN, 10: minimum main-green seconds before a request is served.
- T_YELLOW, 3: yellow seconds, used by both roads.
- T_ALL_RED, 2: all-red clearance seconds.
- T_GREEN_SIDE, 15: side-road green seconds.
- T_PED_WALK, 10: pedestrian walk seconds.
- CNT_W, 8: width of the seconds counter.
- Constraints: all T_* and MIN_GREEN are at least 1 and at most 2^CNT_W-1; TICK_DIV is at least 2.

Ports:
- clock_100mhz, input, 1: system clock.
- rst_n_i, input, 1: asynchronous active-low reset.
- pressed_button_i, input, 1: pedestrian request from the button driver; may stay high for many clock_100mhz cycles.
- side_car_i, input, 1: side-road vehicle present, level.
- main_light_o, output, 3: {red, yellow, green}.
- side_light_o, output, 3: {red, yellow, green}.
- ped_walk_o, output, 1: pedestrian walk lamp.
- ped_request_o, output, 1: pedestrian request pending.
- side_request_o, output, 1: side request pending.
- state_o, output, 3: current FSM state code (debug).
- seconds_left_o, output, CNT_W: remaining seconds of the current phase.

Behaviour:
- Reset is asynchronous and active-low; the block has one clock, clock_100mhz.
- Reset values:
  - state MAIN_GREEN (0); main_light_o=3'b001; side_light_o=3'b100.
  - ped_walk_o=0; both request latches 0.
  - seconds_left_o=MIN_GREEN; prescaler=0.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps; tick is high for one cycle when the count equals TICK_DIV-1.
  - Cleared to 0 on every state transition.
- Phase timer:
  - On entry to a state, seconds_left is loaded with that state's duration.
  - On a tick: if seconds_left==1 in a timed state, transition; otherwise decrement.
  - Each timed state therefore lasts exactly T*TICK_DIV cycles.
- Request latches:
  - Ped latch is set on a rising edge of pressed_button_i. The edge detector is registered, so ped_request_o rises 1 cycle after the input edge.
  - Ped latch is cleared on entry to PED_WALK. Edges that occur while in PED_WALK are ignored.
  - Side latch is set when side_car_i=1 in any state other than SIDE_GREEN and SIDE_YELLOW; it is cleared on entry to SIDE_GREEN.
  - Set and clear in the same cycle: clear wins.
- States (main / side / walk), with transitions:
  - 0 MAIN_GREEN (G/R/0): seconds_left counts down from MIN_GREEN and saturates at 0. Go to MAIN_YELLOW on the first cycle where seconds_left==0 and (ped or side latch set). With no request, stay indefinitely.
  - 1 MAIN_YELLOW (Y/R/0): T_YELLOW, then ALL_RED_1.
  - 2 ALL_RED_1 (R/R/0): T_ALL_RED. Then go to PED_WALK if the ped latch is set, else SIDE_GREEN if the side latch is set, else MAIN_GREEN.
  - 3 PED_WALK (R/R/1): T_PED_WALK, then ALL_RED_2.
  - 4 SIDE_GREEN (R/G/0): T_GREEN_SIDE, then SIDE_YELLOW.
  - 5 SIDE_YELLOW (R/Y/0): T_YELLOW, then ALL_RED_2.
  - 6 ALL_RED_2 (R/R/0): T_ALL_RED, then MAIN_GREEN.
  - Code 7 is illegal and forces MAIN_GREEN on the next cycle.
- Pedestrian service has priority over side service. A side request left pending is served after the next full MIN_GREEN.
- Conflict rule: main and side are never both non-red, and ped_walk_o=1 only while both roads are red.
- All outputs are registered, decoded from the state register.

Decomposition:
- Package intersection_pkg holds:
  - the state enum (codes 0-6);
  - light constants LIGHT_RED=3'b100, LIGHT_YELLOW=3'b010, LIGHT_GREEN=3'b001.
- Sub-module tick_prescaler(clock_100mhz, rst_n_i, clear_i, tick_o) with parameter TICK_DIV.
- The edge detector, latches and FSM stay in the top module.

Test Plan:
- Common sim parameters: TICK_DIV=4, MIN_GREEN=3, T_YELLOW=2, T_ALL_RED=1, T_PED_WALK=3, T_GREEN_SIDE=4.
- Reset, no requests:
  - main_light_o=001, side_light_o=100, seconds_left_o=3 during reset.
  - After release, seconds_left_o reaches 0 at cycle 12 and the FSM stays in MAIN_GREEN for 200 cycles.
- Ped press held 50 cycles at cycle 20 (after min green):
  - ped_request_o=1 at cycle 21; MAIN_YELLOW at cycle 22.
  - Phase lengths: yellow 8 cycles, ALL_RED_1 4, PED_WALK 12 with ped_walk_o=1, ALL_RED_2 4, then MAIN_GREEN.
  - The press is counted exactly once.
- Ped press and side_car_i together at cycle 2:
  - Exit MAIN_GREEN at cycle 12; PED_WALK is served first.
  - Back in MAIN_GREEN, side_request_o stays 1; after 12 cycles of main green, the sequence goes to SIDE_GREEN with side_light_o=001 for 16 cycles.
- Press during PED_WALK → no new request.
- Press during MAIN_YELLOW → latched and served by ALL_RED_1, with no return to main green in between.
- Reset asserted mid-SIDE_GREEN → outputs take MAIN_GREEN values in the same cycle and both latches clear.
- Conflict assertion checked every cycle across all scenarios.
